// File: rtl/alu_sequencer_pkg.sv
// rtl/alu_sequencer_pkg.sv - shared unit/flag/op codes, instruction fields and FSM encoding
package alu_sequencer_pkg;

  localparam int INSTR_WIDTH = 16;

  localparam int UNIT_MSB = 15;
  localparam int UNIT_LSB = 14;
  localparam int OP_MSB   = 13;
  localparam int OP_LSB   = 11;
  localparam int RD_MSB   = 10;
  localparam int RD_LSB   = 8;
  localparam int RA_MSB   = 7;
  localparam int RA_LSB   = 5;
  localparam int RB_MSB   = 4;
  localparam int RB_LSB   = 2;

  typedef enum logic [1:0] {
    UNIT_ALU   = 2'b00,
    UNIT_SHIFT = 2'b01,
    UNIT_LOAD  = 2'b10,
    UNIT_FLAG  = 2'b11
  } unitT;

  typedef enum logic [1:0] {
    IDLE  = 2'b00,
    READ  = 2'b01,
    EXEC  = 2'b10,
    WRITE = 2'b11
  } stateT;

  localparam logic [2:0] FLAG_CLC = 3'b000;
  localparam logic [2:0] FLAG_SEC = 3'b001;
  localparam logic [2:0] FLAG_CMC = 3'b010;

  localparam logic [2:0] ALU_ADD = 3'b000;
  localparam logic [2:0] ALU_ADC = 3'b001;
  localparam logic [2:0] ALU_SUB = 3'b010;
  localparam logic [2:0] ALU_SBC = 3'b011;
  localparam logic [2:0] ALU_AND = 3'b100;
  localparam logic [2:0] ALU_OR  = 3'b101;
  localparam logic [2:0] ALU_XOR = 3'b110;
  localparam logic [2:0] ALU_NOT = 3'b111;

  localparam logic [2:0] SHIFT_SHL = 3'b000;
  localparam logic [2:0] SHIFT_SHR = 3'b001;
  localparam logic [2:0] SHIFT_ROL = 3'b010;
  localparam logic [2:0] SHIFT_ROR = 3'b011;
  localparam logic [2:0] SHIFT_ASR = 3'b100;

endpackage

// File: rtl/alu_sequencer_alu.sv
// rtl/alu_sequencer_alu.sv - combinational Alu: arithmetic/logic, shift and load units with C/Z/N outputs
module alu_sequencer_alu
  import alu_sequencer_pkg::*;
#(
  parameter int DATA_WIDTH = 16
) (
  input  logic [2:0]            operation,
  input  logic [DATA_WIDTH-1:0] operand1,
  input  logic [DATA_WIDTH-1:0] operand2,
  input  logic                  carryIn,
  input  logic                  enableAlu,
  input  logic                  enableShift,
  input  logic                  enableLoad,
  output logic [DATA_WIDTH-1:0] result,
  output logic                  carryOut,
  output logic                  zeroOut,
  output logic                  negativeOut
);

  logic [DATA_WIDTH:0] cinWide;
  logic [DATA_WIDTH:0] oneWide;

  assign cinWide = {{DATA_WIDTH{1'b0}}, carryIn};
  assign oneWide = {{DATA_WIDTH{1'b0}}, 1'b1};

  // Subtraction is a + ~b + 1, so C=1 means no borrow.
  always_comb begin
    result   = '0;
    carryOut = carryIn;
    if (enableAlu) begin
      case (operation)
        ALU_ADD: {carryOut, result} = {1'b0, operand1} + {1'b0, operand2};
        ALU_ADC: {carryOut, result} = {1'b0, operand1} + {1'b0, operand2} + cinWide;
        ALU_SUB: {carryOut, result} = {1'b0, operand1} + {1'b0, ~operand2} + oneWide;
        ALU_SBC: {carryOut, result} = {1'b0, operand1} + {1'b0, ~operand2} + cinWide;
        ALU_AND: result = operand1 & operand2;
        ALU_OR:  result = operand1 | operand2;
        ALU_XOR: result = operand1 ^ operand2;
        default: result = ~operand1;
      endcase
    end else if (enableShift) begin
      case (operation)
        SHIFT_SHL: begin
          result   = {operand1[DATA_WIDTH-2:0], 1'b0};
          carryOut = operand1[DATA_WIDTH-1];
        end
        SHIFT_SHR: begin
          result   = {1'b0, operand1[DATA_WIDTH-1:1]};
          carryOut = operand1[0];
        end
        SHIFT_ROL: begin
          result   = {operand1[DATA_WIDTH-2:0], carryIn};
          carryOut = operand1[DATA_WIDTH-1];
        end
        SHIFT_ROR: begin
          result   = {carryIn, operand1[DATA_WIDTH-1:1]};
          carryOut = operand1[0];
        end
        SHIFT_ASR: begin
          result   = {operand1[DATA_WIDTH-1], operand1[DATA_WIDTH-1:1]};
          carryOut = operand1[0];
        end
        default: result = operand1;
      endcase
    end else if (enableLoad) begin
      result = operand1;
    end
    zeroOut     = (result == '0);
    negativeOut = result[DATA_WIDTH-1];
  end

endmodule

// File: rtl/alu_sequencer.sv
// rtl/alu_sequencer.sv - issue/writeback sequencer around the Alu; ALU_SEQ_DISCARD_R0_EN turns r0 into a no-write sink
module alu_sequencer
  import alu_sequencer_pkg::*;
#(
  parameter int DATA_WIDTH     = 16,
  parameter int REG_ADDR_WIDTH = 3
) (
  input  logic                      clk,
  input  logic                      resetN,
  input  logic [INSTR_WIDTH-1:0]    instr,
  input  logic                      instrValid,
  output logic                      instrReady,
  output logic [REG_ADDR_WIDTH-1:0] regReadAddrA,
  output logic [REG_ADDR_WIDTH-1:0] regReadAddrB,
  input  logic [DATA_WIDTH-1:0]     regReadDataA,
  input  logic [DATA_WIDTH-1:0]     regReadDataB,
  output logic [REG_ADDR_WIDTH-1:0] regWriteAddr,
  output logic [DATA_WIDTH-1:0]     regWriteData,
  output logic                      regWe,
  output logic                      carryFlag,
  output logic                      zeroFlag,
  output logic                      negativeFlag,
  output logic                      done
);

  stateT                     state;
  stateT                     stateNext;
  unitT                      unitReg;
  logic [2:0]                opReg;
  logic [REG_ADDR_WIDTH-1:0] rdReg;
  logic [REG_ADDR_WIDTH-1:0] addrAReg;
  logic [REG_ADDR_WIDTH-1:0] addrBReg;
  logic [DATA_WIDTH-1:0]     operandA;
  logic [DATA_WIDTH-1:0]     operandB;
  logic                      flagDone;

  logic                      accept;
  unitT                      instrUnit;
  logic [2:0]                instrOp;
  logic                      enableAlu;
  logic                      enableShift;
  logic                      enableLoad;
  logic [DATA_WIDTH-1:0]     aluResult;
  logic                      aluCarry;
  logic                      aluZero;
  logic                      aluNegative;
  logic                      unusedInstrBits;

  assign accept          = instrValid && instrReady;
  assign instrUnit       = unitT'(instr[UNIT_MSB:UNIT_LSB]);
  assign instrOp         = instr[OP_MSB:OP_LSB];
  assign unusedInstrBits = ^instr[1:0];

  always_ff @(posedge clk) begin
    if (!resetN) begin
      state <= IDLE;
    end else begin
      state <= stateNext;
    end
  end

  always_comb begin
    stateNext = state;
    case (state)
      IDLE:  if (accept && instrUnit != UNIT_FLAG) stateNext = READ;
      READ:  stateNext = EXEC;
      EXEC:  stateNext = WRITE;
      WRITE: stateNext = IDLE;
    endcase
  end

  // Read addresses come straight from instr in IDLE so the synchronous
  // register file returns data during READ.
  always_comb begin
    instrReady   = (state == IDLE);
    enableAlu    = (state == EXEC) && (unitReg == UNIT_ALU);
    enableShift  = (state == EXEC) && (unitReg == UNIT_SHIFT);
    enableLoad   = (state == EXEC) && (unitReg == UNIT_LOAD);
    done         = (state == WRITE) || flagDone;
    regReadAddrA = addrAReg;
    regReadAddrB = addrBReg;
    if (state == IDLE && instrValid) begin
      regReadAddrA = REG_ADDR_WIDTH'(instr[RA_MSB:RA_LSB]);
      regReadAddrB = REG_ADDR_WIDTH'(instr[RB_MSB:RB_LSB]);
    end
`ifdef ALU_SEQ_DISCARD_R0_EN
    regWe = (state == WRITE) && (regWriteAddr != '0);
`else
    regWe = (state == WRITE);
`endif
  end

  always_ff @(posedge clk) begin
    if (!resetN) begin
      unitReg      <= UNIT_ALU;
      opReg        <= '0;
      rdReg        <= '0;
      addrAReg     <= '0;
      addrBReg     <= '0;
      operandA     <= '0;
      operandB     <= '0;
      regWriteAddr <= '0;
      regWriteData <= '0;
      carryFlag    <= 1'b0;
      zeroFlag     <= 1'b0;
      negativeFlag <= 1'b0;
      flagDone     <= 1'b0;
    end else begin
      flagDone <= 1'b0;
      case (state)
        IDLE: begin
          if (accept) begin
            if (instrUnit == UNIT_FLAG) begin
              flagDone <= 1'b1;
              case (instrOp)
                FLAG_CLC: carryFlag <= 1'b0;
                FLAG_SEC: carryFlag <= 1'b1;
                FLAG_CMC: carryFlag <= ~carryFlag;
                default:  carryFlag <= carryFlag;
              endcase
            end else begin
              unitReg  <= instrUnit;
              opReg    <= instrOp;
              rdReg    <= REG_ADDR_WIDTH'(instr[RD_MSB:RD_LSB]);
              addrAReg <= REG_ADDR_WIDTH'(instr[RA_MSB:RA_LSB]);
              addrBReg <= REG_ADDR_WIDTH'(instr[RB_MSB:RB_LSB]);
            end
          end
        end
        READ: begin
          operandA <= regReadDataA;
          operandB <= regReadDataB;
        end
        EXEC: begin
          regWriteData <= aluResult;
          regWriteAddr <= rdReg;
          carryFlag    <= aluCarry;
          zeroFlag     <= aluZero;
          negativeFlag <= aluNegative;
        end
        default: ;
      endcase
    end
  end

  alu_sequencer_alu #(
    .DATA_WIDTH(DATA_WIDTH)
  ) uAlu (
    .operation  (opReg),
    .operand1   (operandA),
    .operand2   (operandB),
    .carryIn    (carryFlag),
    .enableAlu  (enableAlu),
    .enableShift(enableShift),
    .enableLoad (enableLoad),
    .result     (aluResult),
    .carryOut   (aluCarry),
    .zeroOut    (aluZero),
    .negativeOut(aluNegative)
  );

endmodule

// File: tb/tb_alu_sequencer.sv
// tb/tb_alu_sequencer.sv - self-checking bench for alu_sequencer with a behavioural register file and reference model
module tb_alu_sequencer;

  logic        clk = 1'b0;
  logic        resetN;
  logic [15:0] instr;
  logic        instrValid;
  logic        instrReady;
  logic [2:0]  regReadAddrA;
  logic [2:0]  regReadAddrB;
  logic [15:0] regReadDataA;
  logic [15:0] regReadDataB;
  logic [2:0]  regWriteAddr;
  logic [15:0] regWriteData;
  logic        regWe;
  logic        carryFlag;
  logic        zeroFlag;
  logic        negativeFlag;
  logic        done;

  logic [15:0] rf [8];
  logic        preEn;
  logic [2:0]  preAddr;
  logic [15:0] preData;

  int checks = 0;
  int errors = 0;

  int mrf [8];
  int mC, mZ, mN;
  int expData, expAddr, expWe;

  logic [15:0] obsData;
  logic        obsWe, obsDone, obsC, obsZ, obsN;

  always #5 clk = ~clk;

  alu_sequencer dut (
    .clk         (clk),
    .resetN      (resetN),
    .instr       (instr),
    .instrValid  (instrValid),
    .instrReady  (instrReady),
    .regReadAddrA(regReadAddrA),
    .regReadAddrB(regReadAddrB),
    .regReadDataA(regReadDataA),
    .regReadDataB(regReadDataB),
    .regWriteAddr(regWriteAddr),
    .regWriteData(regWriteData),
    .regWe       (regWe),
    .carryFlag   (carryFlag),
    .zeroFlag    (zeroFlag),
    .negativeFlag(negativeFlag),
    .done        (done)
  );

  always @(posedge clk) begin
    regReadDataA <= rf[regReadAddrA];
    regReadDataB <= rf[regReadAddrB];
    if (preEn) rf[preAddr] <= preData;
    else if (regWe) rf[regWriteAddr] <= regWriteData;
  end

  task automatic checkValue(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
    end
  endtask

  task automatic setReg(input int a, input int d);
    preEn = 1'b1;
    preAddr = 3'(a);
    preData = 16'(d);
    mrf[a] = d;
    @(posedge clk); #1;
    preEn = 1'b0;
  endtask

  // Architectural effect of one instruction, in plain integer arithmetic.
  task automatic modelStep(input logic [15:0] ins);
    int unit, op, rd, a, b, s, r, c, discard;
    unit = int'(ins[15:14]);
    op   = int'(ins[13:11]);
    rd   = int'(ins[10:8]);
    a    = mrf[int'(ins[7:5])];
    b    = mrf[int'(ins[4:2])];
    r = a;
    c = mC;
    if (unit == 3) begin
      if (op == 0) mC = 0;
      else if (op == 1) mC = 1;
      else if (op == 2) mC = 1 - mC;
      return;
    end
    if (unit == 0) begin
      case (op)
        0: s = a + b;
        1: s = a + b + mC;
        2: s = a + (65535 - b) + 1;
        3: s = a + (65535 - b) + mC;
        default: s = 0;
      endcase
      case (op)
        0, 1, 2, 3: begin r = s % 65536; c = s / 65536; end
        4: r = a & b;
        5: r = a | b;
        6: r = a ^ b;
        default: r = 65535 - a;
      endcase
    end else if (unit == 1) begin
      case (op)
        0: begin r = (a * 2) % 65536; c = a / 32768; end
        1: begin r = a / 2; c = a % 2; end
        2: begin r = (a * 2) % 65536 + mC; c = a / 32768; end
        3: begin r = a / 2 + mC * 32768; c = a % 2; end
        4: begin r = a / 2 + ((a >= 32768) ? 32768 : 0); c = a % 2; end
        default: r = a;
      endcase
    end
    discard = 0;
`ifdef ALU_SEQ_DISCARD_R0_EN
    discard = (rd == 0) ? 1 : 0;
`endif
    expData = r;
    expAddr = rd;
    expWe   = 1 - discard;
    mC = c;
    mZ = (r == 0) ? 1 : 0;
    mN = (r >= 32768) ? 1 : 0;
    if (expWe == 1) mrf[rd] = r;
  endtask

  // Entered and left at #1 after a rising edge, cycle 0 being the accept cycle.
  task automatic runInstr(input logic [15:0] ins);
    bit isFlag;
    isFlag = (ins[15:14] == 2'b11);
    instr = ins;
    instrValid = 1'b1;
    checkValue("acceptReady", instrReady, 1);
    modelStep(ins);
    @(posedge clk); #1;
    instrValid = 1'b0;
    instr = 16'($urandom);
    if (isFlag) begin
      obsDone = done; obsWe = regWe; obsC = carryFlag; obsZ = zeroFlag; obsN = negativeFlag;
      checkValue("flagDone", done, 1);
      checkValue("flagWe", regWe, 0);
      checkValue("flagReady", instrReady, 1);
      checkValue("flagC", carryFlag, mC);
      checkValue("flagZ", zeroFlag, mZ);
      checkValue("flagN", negativeFlag, mN);
    end else begin
      checkValue("readReady", instrReady, 0);
      checkValue("readWe", regWe, 0);
      @(posedge clk); #1;
      checkValue("execWe", regWe, 0);
      checkValue("execDone", done, 0);
      @(posedge clk); #1;
      obsData = regWriteData; obsWe = regWe; obsDone = done;
      obsC = carryFlag; obsZ = zeroFlag; obsN = negativeFlag;
      checkValue("wbWe", regWe, expWe);
      checkValue("wbDone", done, 1);
      checkValue("wbReady", instrReady, 0);
      checkValue("wbAddr", regWriteAddr, expAddr);
      checkValue("wbData", regWriteData, expData);
      checkValue("wbC", carryFlag, mC);
      checkValue("wbZ", zeroFlag, mZ);
      checkValue("wbN", negativeFlag, mN);
      @(posedge clk); #1;
      checkValue("retReady", instrReady, 1);
      checkValue("retDone", done, 0);
      checkValue("retWe", regWe, 0);
    end
  endtask

  function automatic logic [15:0] mk(input int unit, input int op, input int rd, input int ra, input int rb);
    return {2'(unit), 3'(op), 3'(rd), 3'(ra), 3'(rb), 2'b00};
  endfunction

  initial begin
    int acc[$];
    int wes[$];
    int expQ[$];
    logic [15:0] seq [3];
    int idx;
    bit accepted;

    resetN = 1'b0;
    instr = '0;
    instrValid = 1'b0;
    preEn = 1'b0;
    preAddr = '0;
    preData = '0;
    mC = 0; mZ = 0; mN = 0;
    repeat (3) @(posedge clk);
    #1;
    checkValue("rstReady", instrReady, 1);
    checkValue("rstWe", regWe, 0);
    checkValue("rstDone", done, 0);
    checkValue("rstFlags", {carryFlag, zeroFlag, negativeFlag}, 0);
    checkValue("rstWAddr", regWriteAddr, 0);
    checkValue("rstWData", regWriteData, 0);
    checkValue("rstRAddr", {regReadAddrA, regReadAddrB}, 0);
    resetN = 1'b1;
    for (int i = 0; i < 8; i++) setReg(i, int'($urandom_range(0, 65535)));

    setReg(1, 'hF000);
    setReg(2, 'h1243);
    runInstr(mk(0, 0, 3, 1, 2));
    checkValue("addData", obsData, 'h0243);
    checkValue("addCZN", {obsC, obsZ, obsN}, 3'b100);

    runInstr(mk(3, 1, 0, 0, 0));
    checkValue("secC", obsC, 1);
    setReg(1, 'h000A);
    setReg(2, 'h000F);
    runInstr(mk(0, 1, 4, 1, 2));
    checkValue("adcData", obsData, 'h001A);
    checkValue("adcC", obsC, 0);

    setReg(1, 'h8234);
    runInstr(mk(1, 0, 5, 1, 0));
    checkValue("shlData", obsData, 'h0468);
    checkValue("shlC", obsC, 1);
    setReg(1, 'h8235);
    runInstr(mk(1, 2, 5, 1, 0));
    checkValue("rolData", obsData, 'h046B);

    runInstr(mk(3, 2, 0, 0, 0));
    runInstr(mk(3, 2, 0, 0, 0));
    runInstr(mk(3, 0, 0, 0, 0));
    checkValue("clcC", obsC, 0);

    for (int i = 0; i < 3; i++)
      seq[i] = mk(0, int'($urandom_range(0, 7)), int'($urandom_range(1, 7)),
                  int'($urandom_range(0, 7)), int'($urandom_range(0, 7)));
    idx = 0;
    instr = seq[0];
    instrValid = 1'b1;
    for (int cyc = 0; cyc < 16; cyc++) begin
      if (regWe) begin
        wes.push_back(cyc);
        if (expQ.size() > 0) checkValue("b2bData", regWriteData, expQ.pop_front());
      end
      accepted = instrValid && instrReady;
      if (accepted) begin
        acc.push_back(cyc);
        modelStep(instr);
        expQ.push_back(expData);
      end
      @(posedge clk); #1;
      if (accepted) begin
        idx++;
        if (idx < 3) instr = seq[idx];
        else instrValid = 1'b0;
      end
    end
    checkValue("b2bAccCount", acc.size(), 3);
    checkValue("b2bWeCount", wes.size(), 3);
    for (int i = 0; i < 3; i++) begin
      if (i < acc.size()) checkValue("b2bAccCycle", acc[i], 4 * i);
      if (i < wes.size()) checkValue("b2bWeCycle", wes[i], 4 * i + 3);
    end
    checkValue("b2bC", carryFlag, mC);

    setReg(1, 'hF000);
    setReg(2, 'h1243);
    instr = mk(0, 0, 6, 1, 2);
    instrValid = 1'b1;
    @(posedge clk); #1;
    instrValid = 1'b0;
    @(posedge clk); #1;
    resetN = 1'b0;
    @(posedge clk); #1;
    checkValue("abortWe", regWe, 0);
    checkValue("abortDone", done, 0);
    checkValue("abortFlags", {carryFlag, zeroFlag, negativeFlag}, 0);
    resetN = 1'b1;
    mC = 0; mZ = 0; mN = 0;
    @(posedge clk); #1;
    checkValue("abortReady", instrReady, 1);
    checkValue("abortWe2", regWe, 0);

    setReg(1, 'h8235);
    runInstr(mk(0, 7, 0, 1, 0));
`ifdef ALU_SEQ_DISCARD_R0_EN
    checkValue("r0We", obsWe, 0);
    checkValue("r0ZN", {obsZ, obsN}, 0);
    checkValue("r0Done", obsDone, 1);
`else
    checkValue("r0We", obsWe, 1);
    checkValue("r0Data", obsData, 'h7DCA);
`endif

    for (int i = 0; i < 40; i++) runInstr(16'($urandom));
    for (int i = 0; i < 8; i++) checkValue("rfFinal", rf[i], mrf[i]);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
